ghash_core: RTL
===============

# ghash_core

GHASH accumulation engine for the AES-GCM datapath. It sits directly upstream of `gfmul` and owns the running hash `Y`. It accepts AAD blocks, then ciphertext blocks, over a valid/ready handshake. For each accepted block it feeds `Y ^ X` and the hash key into a `gfmul` instance and writes the product back into `Y`. After the last data block it appends the `len(A)||len(C)` block automatically and delivers the final GHASH (or tag) with a done pulse.

## Interface
Parameters:
- `LEN_W`, 64 — width of each bit-length counter; fixed by GCM, exposed for test shrinking only.

Ports:
- `clk`  in  1  — single clock for the whole block.
- `rst`  in  1  — asynchronous, active-high reset.
- `iStart`  in  1  — begin a new message; sampled only in IDLE.
- `iHashkey`  in  [0:127]  — H; latched on the accepted `iStart`.
- `iBlock`  in  [0:127]  — data block, MSB-first (bit 0 = first bit).
- `iBytes`  in  5  — valid bytes in `iBlock`, 0..16; bytes past this count are forced to zero.
- `iType`  in  1  — 0 = AAD, 1 = ciphertext.
- `iLast`  in  1  — final data block of the message.
- `iValid`  in  1  — `iBlock`/`iBytes`/`iType`/`iLast` valid.
- `oReady`  out  1  — block can accept data.
- `oGhash`  out  [0:127]  — final GHASH (tag when `GHASH_TAG_EN` is defined).
- `oDone`  out  1  — one-cycle pulse; `oGhash` is valid from this cycle until the next accepted `iStart`.
- `oErr`  out  1  — sticky protocol error; cleared by an accepted `iStart`.

## Operation
- **States:** IDLE, ABSORB, MWAIT, LEN, LWAIT, DONE.
- **IDLE**
  - `iStart=1`: latch H, clear `Y`, `lenA`, `lenC` and `oErr`; go to ABSORB.
  - Other inputs are ignored. `iStart` is ignored in every other state.
- **ABSORB**
  - `oReady=1`.
  - Handshake is `iValid & oReady`.
  - The `gfmul` operand is `Y ^ pad(iBlock, iBytes)`.
  - On handshake with `iBytes>0`:
    - Add `iBytes*8` to `lenA` (`iType=0`) or `lenC` (`iType=1`), modulo 2^LEN_W.
    - Go to MWAIT.
  - On handshake with `iBytes=0`: the block is not absorbed and not counted. If `iLast=1`, go to LEN; otherwise stay in ABSORB. This is how empty messages finish.
  - The `iLast` of an absorbed block is remembered for MWAIT.
- **MWAIT**
  - `oReady=0`.
  - `Y <= gfmul.oResult`.
  - Next state is LEN if the remembered `iLast` was 1, else ABSORB.
- **LEN**
  - The operand is `Y ^ {lenA, lenC}` (`lenA` in bits 0..63).
  - Go to LWAIT.
- **LWAIT**
  - Capture the `gfmul` result into `oGhash` (XORed with the tag term if `GHASH_TAG_EN` is defined).
  - Assert `oDone` and go to DONE.
- **DONE**
  - Go to IDLE after one cycle; `oGhash` holds.
- **Ordering rule:** an AAD block accepted after any ciphertext block sets `oErr`. The block is still absorbed.
- `iBytes>16` is treated as 16 and sets `oErr`.
- **Reset:** applies asynchronously at any point, including mid-message.
  - All state returns to IDLE.
  - `Y`, H, `lenA`, `lenC`, `oGhash`, `oErr` = 0; `oDone`, `oReady` = 0.
  - The `gfmul` instance shares `rst`.

## Timing
- `gfmul` has a registered output: the operand presented at edge N yields its product after edge N.
- Throughput is one absorbed block per 2 cycles: `oReady` is low for exactly one cycle after each absorbed block.
- Last absorbed block accepted at edge E0:
  - E1: `Y` updated, enter LEN.
  - E2: length product launched.
  - E3: `oGhash` registered and `oDone=1` for the cycle after E3.
- Empty finish (`iBytes=0`, `iLast=1`) at E0: `oDone` is high after E2.
- After `oDone`, a new `iStart` is accepted no earlier than 2 edges later (DONE, then IDLE).

## Configuration
- `GHASH_TAG_EN` defined:
  - Adds input `iEj0 [0:127]`, latched on `iStart`.
  - `oGhash = GHASH ^ iEj0`, i.e. the GCM tag.
- Not defined:
  - No `iEj0` port.
  - `oGhash` is the raw GHASH value.

## Structure
- **Shared package:**
  - State enum.
  - Reduction constant `R = 8'hE1 << 120`, shared with `gfmul`.
  - `LEN_W` default.
  - Byte-mask function for `pad()`.
- **Sub-module:** one instance of the existing `gfmul` (`iCtext` = operand mux, `iHashkey` = latched H). No other sub-modules.

## Test plan
- **Empty message:**
  - Stimulus: H=66e94bd4ef8a2c3b884cfa59ca342b2e; `iStart`, then one `iBytes=0`, `iLast=1` handshake.
  - Raw GHASH = 0 → `oGhash`=0 without the tag macro.
  - With `GHASH_TAG_EN` and `iEj0`=58e2fccefa7e3061367f1d57a4e7455a → `oGhash`=58e2fccefa7e3061367f1d57a4e7455a.
  - `oDone` is high exactly one cycle.
- **NIST GCM case 2, `GHASH_TAG_EN` defined:**
  - Stimulus: same H and `iEj0`; one CT block 0388dace60b6a392f328c2b971b2fe78, `iBytes=16`, `iLast=1`.
  - → `oGhash`=ab6e47d42cec13bdf53a67b21257bddf.
  - `lenC`=128, `lenA`=0.
  - `oDone` high in the cycle after the 3rd edge following the data accept.
- **Partial block:**
  - Stimulus: 20-byte AAD (16 + 4 bytes, garbage in the unused bytes), then one 16-byte CT block.
  - → Result matches the software model with zero padding.
  - `lenA`=160, `lenC`=128.
- **Backpressure:**
  - Stimulus: hold `iValid` high across 4 blocks.
  - → `oReady` toggles 1,0,1,0…; exactly 4 absorptions; result matches the model.
- **Protocol error:**
  - Stimulus: CT block followed by an AAD block.
  - → `oErr`=1 and held sticky through `oDone`; it clears on the next accepted `iStart`.
- **Reset mid-op:**
  - Stimulus: assert `rst` during MWAIT.
  - → All outputs are 0 immediately (asynchronous); a following message computes correctly from `Y`=0.

Source files
------------

// File: rtl/ghash_core_pkg.sv
// Shared definitions for the GHASH accumulation engine and its GF(2^128) multiplier.
package ghash_core_pkg;

  localparam int LEN_W_DEF = 64;

  // GCM reduction polynomial, i.e. 8'hE1 << 120 with bit 0 as the MSB
  localparam logic [0:127] GF_R = {8'hE1, 120'h0};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ABSORB = 3'd1,
    ST_MWAIT  = 3'd2,
    ST_LEN    = 3'd3,
    ST_LWAIT  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  function automatic logic [0:127] byte_mask(input logic [4:0] nbytes);
    logic [0:127] m;
    m = 128'h0;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < nbytes) begin
        m[8*i +: 8] = 8'hFF;
      end else begin
        m[8*i +: 8] = 8'h00;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/ghash_core_gfmul.sv
// GF(2^128) multiplier in GCM bit order; the product is registered one cycle after the operands.
module gfmul
  import ghash_core_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [0:127] iCtext,
  input  logic [0:127] iHashkey,
  output logic [0:127] oResult
);

  function automatic logic [0:127] gf_mult(input logic [0:127] x, input logic [0:127] y);
    logic [0:127] z;
    logic [0:127] v;
    z = 128'h0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[i]) begin
        z = z ^ v;
      end else begin
        z = z;
      end
      v = v[127] ? ((v >> 1) ^ GF_R) : (v >> 1);
    end
    return z;
  endfunction

  // product register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oResult <= 128'h0;
    end else begin
      oResult <= gf_mult(iCtext, iHashkey);
    end
  end

endmodule

// File: rtl/ghash_core.sv
// GHASH accumulator: absorbs AAD then ciphertext blocks, appends len(A)||len(C), emits the hash.
// Optional GHASH_TAG_EN adds iEj0 and outputs the GCM tag instead of the raw GHASH.
module ghash_core
  import ghash_core_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         iStart,
  input  logic [0:127] iHashkey,
`ifdef GHASH_TAG_EN
  input  logic [0:127] iEj0,
`endif
  input  logic [0:127] iBlock,
  input  logic [4:0]   iBytes,
  input  logic         iType,
  input  logic         iLast,
  input  logic         iValid,
  output logic         oReady,
  output logic [0:127] oGhash,
  output logic         oDone,
  output logic         oErr
);

  state_t             state_r, state_n;
  logic [0:127]       h_r, y_r, ghash_r;
  logic [0:127]       operand_s, product_s, pad_s, len_blk_s, tag_term_s;
  logic [LEN_W-1:0]   len_a_r, len_c_r, bits_s;
  logic [4:0]         bytes_eff_s;
  logic               last_r, seen_ct_r, err_r, done_r, ready_r;
  logic               start_s, absorb_s, set_err_s;

`ifdef GHASH_TAG_EN
  logic [0:127] ej0_r;
  assign tag_term_s = ej0_r;
`else
  assign tag_term_s = 128'h0;
`endif

  assign bytes_eff_s = (iBytes > 5'd16) ? 5'd16 : iBytes;
  assign pad_s       = iBlock & byte_mask(bytes_eff_s);
  assign bits_s      = LEN_W'({bytes_eff_s, 3'b000});
  assign len_blk_s   = {64'(len_a_r), 64'(len_c_r)};
  assign operand_s   = (state_r == ST_LEN) ? (y_r ^ len_blk_s) : (y_r ^ pad_s);
  // oversize counts and AAD after ciphertext are both protocol errors
  assign set_err_s   = absorb_s & ((iBytes > 5'd16) | (~iType & seen_ct_r));

  gfmul u_gfmul (
    .clk      (clk),
    .rst      (rst),
    .iCtext   (operand_s),
    .iHashkey (h_r),
    .oResult  (product_s)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // next-state and handshake decode
  always_comb begin
    state_n  = state_r;
    start_s  = 1'b0;
    absorb_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (iStart) begin
          start_s = 1'b1;
          state_n = ST_ABSORB;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ABSORB: begin
        if (iValid && (iBytes != 5'd0)) begin
          absorb_s = 1'b1;
          state_n  = ST_MWAIT;
        end else if (iValid && iLast) begin
          state_n = ST_LEN;
        end else begin
          state_n = ST_ABSORB;
        end
      end
      ST_MWAIT: state_n = last_r ? ST_LEN : ST_ABSORB;
      ST_LEN:   state_n = ST_LWAIT;
      ST_LWAIT: state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // hash datapath, length counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_r       <= 128'h0;
      y_r       <= 128'h0;
      ghash_r   <= 128'h0;
      len_a_r   <= '0;
      len_c_r   <= '0;
      last_r    <= 1'b0;
      seen_ct_r <= 1'b0;
      err_r     <= 1'b0;
      done_r    <= 1'b0;
      ready_r   <= 1'b0;
`ifdef GHASH_TAG_EN
      ej0_r     <= 128'h0;
`endif
    end else begin
      ready_r <= (state_n == ST_ABSORB);
      done_r  <= (state_r == ST_LWAIT);
      if (start_s) begin
        h_r       <= iHashkey;
        y_r       <= 128'h0;
        len_a_r   <= '0;
        len_c_r   <= '0;
        last_r    <= 1'b0;
        seen_ct_r <= 1'b0;
        err_r     <= 1'b0;
`ifdef GHASH_TAG_EN
        ej0_r     <= iEj0;
`endif
      end else begin
        if (absorb_s) begin
          last_r <= iLast;
          if (iType) begin
            len_c_r   <= len_c_r + bits_s;
            seen_ct_r <= 1'b1;
          end else begin
            len_a_r <= len_a_r + bits_s;
          end
        end
        if (set_err_s) begin
          err_r <= 1'b1;
        end
        if (state_r == ST_MWAIT) begin
          y_r <= product_s;
        end
        if (state_r == ST_LWAIT) begin
          ghash_r <= product_s ^ tag_term_s;
        end
      end
    end
  end

  assign oReady = ready_r;
  assign oDone  = done_r;
  assign oErr   = err_r;
  assign oGhash = ghash_r;

endmodule
